// File: rtl/mdu_hilo_engine.sv
// mdu_hilo_engine: multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU compute their result at the launch edge into pending
// registers. A busy counter then models the multi-cycle latency. HI/LO are
// written only when the counter expires. MTHI/MTLO write directly when the
// unit is idle.
// Optional feature macro: MDU_CANCEL_EN. It adds the Req input, which
// suppresses a launch or an MTxx write in the cycle where Req is high.
// Handshake: Start is a one-cycle launch request. It is accepted only while
// Busy=0 and MDUOP is arithmetic. Busy stays high for exactly N cycles after
// acceptance. New HI/LO values are visible in the cycle after Busy falls.
module mdu_hilo_engine #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOP,
  input  logic [1:0]  ReadHILO,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
  input  logic        Req,
`endif
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut,
  output logic        dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;

  logic          cancel;
  logic          is_arith;
  logic          launch;
  logic          mt_hi;
  logic          mt_lo;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          a_neg;
  logic          b_neg;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   div_u;
  logic [31:0]   div_s;
  logic [31:0]   q_u;
  logic [31:0]   r_u;
  logic [31:0]   q_m;
  logic [31:0]   r_m;

  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_wr;
  logic [CW-1:0] res_n;

`ifdef MDU_CANCEL_EN
  assign cancel = Req;
`else
  assign cancel = 1'b0;
`endif

  assign is_arith = (MDUOP == OP_MULT) || (MDUOP == OP_MULTU) ||
                    (MDUOP == OP_DIV)  || (MDUOP == OP_DIVU);
  assign launch   = (state == S_IDLE) && Start && is_arith && !cancel;
  // A Start in the same cycle takes priority, so it drops the MTxx write.
  assign mt_hi    = (state == S_IDLE) && !Start && (MDUOP == OP_MTHI) && !cancel;
  assign mt_lo    = (state == S_IDLE) && !Start && (MDUOP == OP_MTLO) && !cancel;

  // The low 64 bits of the sign-extended product equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'h0, A} * {32'h0, B};

  // A signed divide is done on magnitudes, then the signs are restored.
  // 0x80000000 / -1 then yields 0x80000000 with remainder 0 on its own.
  assign a_neg = A[31];
  assign b_neg = B[31];
  assign a_mag = a_neg ? (32'h0 - A) : A;
  assign b_mag = b_neg ? (32'h0 - B) : B;
  // A zero divisor is replaced by 1 only to keep the arithmetic defined.
  // The result is discarded through res_wr.
  assign div_u = (B == 32'h0) ? 32'h1 : B;
  assign div_s = (B == 32'h0) ? 32'h1 : b_mag;
  assign q_u   = A / div_u;
  assign r_u   = A % div_u;
  assign q_m   = a_mag / div_s;
  assign r_m   = a_mag % div_s;

  // Select the pending result and the latency for the requested operation.
  always_comb begin
    res_hi = 32'h0;
    res_lo = 32'h0;
    res_wr = 1'b0;
    res_n  = CW'(MULT_CYCLES);
    case (MDUOP)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_wr = 1'b1; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_wr = 1'b1; end
      OP_DIV: begin
        res_lo = (a_neg ^ b_neg) ? (32'h0 - q_m) : q_m;
        res_hi = a_neg ? (32'h0 - r_m) : r_m;
        res_wr = (B != 32'h0);
        res_n  = CW'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_lo = q_u;
        res_hi = r_u;
        res_wr = (B != 32'h0);
        res_n  = CW'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  // Control FSM, latency counter, pending result and the HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      Busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
      pend_wr <= 1'b0;
      HI      <= 32'h0;
      LO      <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            cnt     <= res_n;
            Busy    <= 1'b1;
            state   <= S_BUSY;
          end else if (mt_hi) begin
            HI <= A;
          end else if (mt_lo) begin
            LO <= A;
          end
        end
        S_BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            if (pend_wr) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = (state == S_BUSY);

  // Read mux for MFHI/MFLO; it returns committed values only.
  always_comb begin
    MDUOut = 32'h0;
    case (ReadHILO)
      2'b10:   MDUOut = HI;
      2'b01:   MDUOut = LO;
      default: MDUOut = 32'h0;
    endcase
  end

endmodule
